// File: rtl/truth_table_checker.sv
// Checks sampled responses of a 3-input, 2-output device against parameter truth tables.
// It collects mismatch statistics and ends a run when all 8 vectors have been seen or when sampling goes idle too long.
module truth_table_checker #(
    parameter logic [7:0]  EXP_Y   = 8'hE8,
    parameter logic [7:0]  EXP_X   = 8'h96,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       smp_valid,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       y,
    input  logic       x,
    output logic       smp_ready,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic       first_fail_vld,
    output logic [7:0] seen
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    state_e     state_q, state_d;
    logic       smp_ready_q, smp_ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       timeout_q, timeout_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [2:0] first_fail_q, first_fail_d;
    logic       first_fail_vld_q, first_fail_vld_d;
    logic [7:0] seen_q, seen_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;

    logic [2:0] idx;
    logic       accept;
    logic       mismatch;
    logic [7:0] idle_inc;

    assign idx      = {a, b, c};
    assign accept   = smp_ready_q && smp_valid;
    assign mismatch = (y != EXP_Y[idx]) || (x != EXP_X[idx]);
    assign idle_inc = idle_cnt_q + 8'd1;

    always_comb begin
        state_d          = state_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        err_cnt_d        = err_cnt_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;
        seen_d           = seen_q;
        idle_cnt_d       = idle_cnt_q;

        // start takes priority from every state and drops any sample offered with it
        if (start) begin
            state_d          = CHECK;
            pass_d           = 1'b0;
            timeout_d        = 1'b0;
            err_cnt_d        = 4'd0;
            first_fail_d     = 3'd0;
            first_fail_vld_d = 1'b0;
            seen_d           = 8'h00;
            idle_cnt_d       = 8'd0;
        end else if (state_q == CHECK) begin
            if (accept) begin
                idle_cnt_d = 8'd0;
                seen_d     = seen_q | (8'd1 << idx);
                if (mismatch) begin
                    if (err_cnt_q != 4'hF) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
                    if (!first_fail_vld_q) begin
                        first_fail_d     = idx;
                        first_fail_vld_d = 1'b1;
                    end
                end
                if (seen_d == 8'hFF) begin
                    state_d = DONE;
                    pass_d  = (err_cnt_d == 4'd0);
                end
            end else begin
                idle_cnt_d = idle_inc;
                if (idle_inc >= TIMEOUT_C) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
        end

        smp_ready_d = (state_d == CHECK);
        busy_d      = (state_d == CHECK);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            smp_ready_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_cnt_q        <= 4'd0;
            first_fail_q     <= 3'd0;
            first_fail_vld_q <= 1'b0;
            seen_q           <= 8'h00;
            idle_cnt_q       <= 8'd0;
        end else begin
            state_q          <= state_d;
            smp_ready_q      <= smp_ready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            err_cnt_q        <= err_cnt_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
            seen_q           <= seen_d;
            idle_cnt_q       <= idle_cnt_d;
        end
    end

    assign smp_ready      = smp_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_cnt_q;
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;
    assign seen           = seen_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed runs plus random traffic.
// Each cycle is compared against a run-level reference model.
module tb_truth_table_checker;

    localparam logic [7:0] TB_EXP_Y   = 8'hE8;
    localparam logic [7:0] TB_EXP_X   = 8'h96;
    localparam int         TB_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       smp_valid = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, y = 1'b0, x = 1'b0;
    logic       smp_ready, busy, done, pass, timeout, first_fail_vld;
    logic [3:0] err_cnt;
    logic [2:0] first_fail;
    logic [7:0] seen;

    int total = 0;
    int bad = 0;

    // reference model: 0 = idle, 1 = checking, 2 = finished
    int         m_mode;
    logic [7:0] m_seen;
    int         m_errs;
    int         m_idle;
    logic [2:0] m_ff;
    logic       m_ffv, m_pass, m_to;

    truth_table_checker #(
        .EXP_Y  (TB_EXP_Y),
        .EXP_X  (TB_EXP_X),
        .TIMEOUT(TB_TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .smp_valid     (smp_valid),
        .a             (a),
        .b             (b),
        .c             (c),
        .y             (y),
        .x             (x),
        .smp_ready     (smp_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_fail    (first_fail),
        .first_fail_vld(first_fail_vld),
        .seen          (seen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_y_of(input int v);
        return ((TB_EXP_Y >> v) & 8'd1) != 8'd0;
    endfunction

    function automatic logic exp_x_of(input int v);
        return ((TB_EXP_X >> v) & 8'd1) != 8'd0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_seen = 8'h00; m_errs = 0; m_idle = 0;
        m_ff = 3'd0; m_ffv = 1'b0; m_pass = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_cycle(input logic st, input logic v, input int vec, input logic yy, input logic xx);
        if (st) begin
            model_reset();
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (v) begin
                m_idle = 0;
                m_seen[vec] = 1'b1;
                if (yy != exp_y_of(vec) || xx != exp_x_of(vec)) begin
                    m_errs = (m_errs < 15) ? m_errs + 1 : 15;
                    if (!m_ffv) begin
                        m_ff  = 3'(vec);
                        m_ffv = 1'b1;
                    end
                end
                if (m_seen == 8'hFF) begin
                    m_mode = 2;
                    m_pass = (m_errs == 0);
                end
            end else begin
                m_idle++;
                if (m_idle >= TB_TIMEOUT) begin
                    m_mode = 2;
                    m_to   = 1'b1;
                    m_pass = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".ready"}, 32'(smp_ready), 32'(m_mode == 1));
        check_eq({tag, ".busy"}, 32'(busy), 32'(m_mode == 1));
        check_eq({tag, ".done"}, 32'(done), 32'(m_mode == 2));
        check_eq({tag, ".pass"}, 32'(pass), 32'(m_pass));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        check_eq({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errs));
        check_eq({tag, ".first_fail"}, 32'(first_fail), 32'(m_ff));
        check_eq({tag, ".ffv"}, 32'(first_fail_vld), 32'(m_ffv));
        check_eq({tag, ".seen"}, 32'(seen), 32'(m_seen));
    endtask

    // Drive one cycle of inputs, advance the model, then check just after the edge.
    task automatic step(input string tag, input logic st, input logic v, input int vec,
                        input logic yy, input logic xx);
        start = st; smp_valid = v;
        {a, b, c} = 3'(vec);
        y = yy; x = xx;
        @(posedge clk);
        model_cycle(st, v, vec, yy, xx);
        #1;
        check_all(tag);
    endtask

    task automatic send_ok(input string tag, input int vec);
        step(tag, 1'b0, 1'b1, vec, exp_y_of(vec), exp_x_of(vec));
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("after_reset", 2);
        // samples while idle are ignored
        send_ok("idle_sample", 3);

        // all eight correct, back-to-back
        step("r35_start", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++) send_ok("r35_vec", v);
        check_eq("r35_done", 32'(done), 32'd1);
        check_eq("r35_pass", 32'(pass), 32'd1);
        check_eq("r35_seen", 32'(seen), 32'hFF);
        idle("r35_hold", 2);
        send_ok("r35_ignored", 0);

        // y inverted on 011 and 101
        step("r36_start", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++)
            step("r36_vec", 1'b0, 1'b1, v, exp_y_of(v) ^ (v == 3 || v == 5), exp_x_of(v));
        check_eq("r36_err", 32'(err_cnt), 32'd2);
        check_eq("r36_ff", 32'(first_fail), 32'd3);
        check_eq("r36_ffv", 32'(first_fail_vld), 32'd1);
        check_eq("r36_pass", 32'(pass), 32'd0);

        // 20 wrong duplicates of 000, then all eight
        step("r37_start", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("r37_bad", 1'b0, 1'b1, 0, 1'b1, exp_x_of(0));
        for (int v = 0; v < 8; v++) send_ok("r37_vec", v);
        check_eq("r37_err", 32'(err_cnt), 32'd15);
        check_eq("r37_pass", 32'(pass), 32'd0);
        check_eq("r37_done", 32'(done), 32'd1);

        // idle timeout after three vectors
        step("r38_start", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int v = 0; v < 3; v++) send_ok("r38_vec", v);
        idle("r38_idle", TB_TIMEOUT - 1);
        check_eq("r38_not_yet", 32'(done), 32'd0);
        idle("r38_idle", 1);
        check_eq("r38_done", 32'(done), 32'd1);
        check_eq("r38_timeout", 32'(timeout), 32'd1);
        check_eq("r38_pass", 32'(pass), 32'd0);
        check_eq("r38_seen", 32'(seen), 32'h07);

        // restart mid-run with a bad sample on the start cycle
        step("r39_start", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int v = 0; v < 5; v++) step("r39_vec", 1'b0, 1'b1, v, ~exp_y_of(v), exp_x_of(v));
        step("r39_restart", 1'b1, 1'b1, 6, ~exp_y_of(6), exp_x_of(6));
        check_eq("r39_seen", 32'(seen), 32'h00);
        check_eq("r39_err", 32'(err_cnt), 32'd0);
        check_eq("r39_busy", 32'(busy), 32'd1);

        // start on the cycle that would complete the set
        for (int v = 0; v < 7; v++) send_ok("r32_vec", v);
        step("r32_clash", 1'b1, 1'b1, 7, exp_y_of(7), exp_x_of(7));
        check_eq("r32_seen", 32'(seen), 32'h00);

        // asynchronous reset in the middle of a run
        for (int v = 0; v < 3; v++) step("r40_vec", 1'b0, 1'b1, v, 1'b1, 1'b1);
        start = 1'b0; smp_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("r40_async");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle("r40_after", 3);
        check_eq("r40_idle_busy", 32'(busy), 32'd0);
        send_ok("r40_ignored", 4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            int vec;
            logic st, v, yy, xx;
            vec = $urandom_range(0, 7);
            st  = ($urandom_range(0, 29) == 0);
            v   = ($urandom_range(0, 9) < 7);
            yy  = exp_y_of(vec) ^ ($urandom_range(0, 19) == 0);
            xx  = exp_x_of(vec) ^ ($urandom_range(0, 19) == 0);
            step("rand", st, v, vec, yy, xx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
